stack_access_ctrl: RTL and testbench

//  Initiator side of the byte-addressed stack RAM port: sequences PUSH/POP/PEEK requests from the core.

---
 rtl/stack_access_ctrl_pkg.sv | 23 ++
 rtl/stack_access_ctrl_if.sv | 32 +++
 rtl/stack_access_ctrl.sv | 113 +++++++++++
 tb/tb_stack_access_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_access_ctrl_pkg.sv
// rtl/stack_access_ctrl_pkg.sv - shared op codes, FSM states and word size for the stack port
package stack_access_ctrl_pkg;

  localparam int WORD_BYTES = 4;

  // 2'b00 is reserved and is treated as a PEEK by the controller
  typedef enum logic [1:0] {
    OP_RSVD = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_PEEK = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PUSH_ADJ = 3'd1,
    S_PUSH_WR  = 3'd2,
    S_POP_RD   = 3'd3,
    S_POP_ADJ  = 3'd4,
    S_DONE     = 3'd5
  } state_e;

endpackage

// File: rtl/stack_access_ctrl_if.sv
// rtl/stack_access_ctrl_if.sv - core request/response and stack RAM signals
// slave is the controller; master is the core plus RAM side.
interface stack_access_ctrl_if #(
  parameter int ADDR_W = 32
) ();

  logic              op_valid;
  logic              op_ready;
  logic [1:0]        op_code;
  logic [31:0]       op_wdata;
  logic              esp_load;
  logic [ADDR_W-1:0] esp_in;
  logic [ADDR_W-1:0] esp;
  logic              resp_valid;
  logic [31:0]       resp_data;
  logic              resp_err;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  op_valid, op_code, op_wdata, esp_load, esp_in, mem_rdata,
    output op_ready, esp, resp_valid, resp_data, resp_err, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output op_valid, op_code, op_wdata, esp_load, esp_in, mem_rdata,
    input  op_ready, esp, resp_valid, resp_data, resp_err, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/stack_access_ctrl.sv
// rtl/stack_access_ctrl.sv - PUSH/POP/PEEK sequencer owning ESP and the stack RAM port
// Optional STACK_BOUNDS_CHECK_EN adds over/underflow detection reported on resp_err.
module stack_access_ctrl
  import stack_access_ctrl_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] STACK_TOP   = 'h200,
  parameter logic [ADDR_W-1:0] STACK_LIMIT = 'h000
) (
  input  logic               clk,
  input  logic               reset,
  stack_access_ctrl_if.slave bus
);

  localparam logic [ADDR_W-1:0] W_STEP = ADDR_W'(WORD_BYTES);

  state_e            r_state;
  state_e            w_next;
  logic [ADDR_W-1:0] r_esp;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_is_pop;
  logic              r_err;
  logic              w_accept;
  logic              w_viol;

  assign bus.op_ready  = (r_state == S_IDLE) && !bus.esp_load && !reset;
  assign w_accept      = bus.op_valid && bus.op_ready;
  assign bus.esp       = r_esp;
  assign bus.mem_addr  = r_esp;
  assign bus.mem_wdata = r_wdata;
  assign bus.resp_data = r_rdata;

`ifdef STACK_BOUNDS_CHECK_EN
  logic w_push_viol;
  logic w_pop_viol;

  assign w_push_viol  = r_esp < (STACK_LIMIT + W_STEP);
  assign w_pop_viol   = r_esp > (STACK_TOP - W_STEP);
  assign w_viol       = (bus.op_code == OP_PUSH) ? w_push_viol :
                        (bus.op_code == OP_POP)  ? w_pop_viol  : 1'b0;
  assign bus.resp_err = r_err;
`else
  assign w_viol       = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A faulted op still walks PUSH_WR / POP_ADJ so that latency is identical,
  // but neither writes RAM nor moves ESP there.
  always_comb begin
    w_next         = r_state;
    bus.mem_we     = 1'b0;
    bus.resp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = (bus.op_code == OP_PUSH) ? S_PUSH_ADJ : S_POP_RD;
        end
      end
      S_PUSH_ADJ: w_next = S_PUSH_WR;
      S_PUSH_WR: begin
        bus.mem_we = !r_err;
        w_next     = S_DONE;
      end
      S_POP_RD:  w_next = r_is_pop ? S_POP_ADJ : S_DONE;
      S_POP_ADJ: w_next = S_DONE;
      S_DONE: begin
        bus.resp_valid = 1'b1;
        w_next         = S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_esp    <= STACK_TOP;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_is_pop <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && bus.esp_load) begin
        r_esp <= bus.esp_in;
      end
      if (w_accept) begin
        r_is_pop <= (bus.op_code == OP_POP);
        r_err    <= w_viol;
        if (bus.op_code == OP_PUSH) begin
          r_wdata <= bus.op_wdata;
        end
      end
      if ((r_state == S_PUSH_ADJ) && !r_err) begin
        r_esp <= r_esp - W_STEP;
      end
      if ((r_state == S_POP_ADJ) && !r_err) begin
        r_esp <= r_esp + W_STEP;
      end
      if (r_state == S_POP_RD) begin
        r_rdata <= r_err ? 32'h0 : bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_stack_access_ctrl.sv
// tb/tb_stack_access_ctrl.sv - directed self-checking bench for stack_access_ctrl
module tb_stack_access_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   wr_cnt = 0;
  int   rv_cnt = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_data = '0;
  logic [7:0]  ram [0:1023] = '{default: 8'h00};
  logic [9:0]  w_a;

  always #5 clk = ~clk;

  stack_access_ctrl_if #(.ADDR_W(32)) bus ();

  stack_access_ctrl #(
    .ADDR_W(32),
    .STACK_TOP(32'h200),
    .STACK_LIMIT(32'h0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  assign w_a = bus.mem_addr[9:0];
  assign bus.mem_rdata = {ram[w_a + 10'd3], ram[w_a + 10'd2], ram[w_a + 10'd1], ram[w_a]};

  always @(posedge clk) begin
    if (bus.mem_we) begin
      ram[w_a]         <= bus.mem_wdata[7:0];
      ram[w_a + 10'd1] <= bus.mem_wdata[15:8];
      ram[w_a + 10'd2] <= bus.mem_wdata[23:16];
      ram[w_a + 10'd3] <= bus.mem_wdata[31:24];
      wr_cnt    <= wr_cnt + 1;
      last_addr <= bus.mem_addr;
      last_data <= bus.mem_wdata;
    end
    if (bus.resp_valid) rv_cnt <= rv_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge where resp_valid is high; lat counts edges from accept.
  task automatic run_op(input logic [1:0] code, input logic [31:0] wd, output int lat);
    int n;
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.op_wdata = wd;
    n = 0;
    #1;
    while (!bus.op_ready && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.op_valid = 1'b0;
    while (!bus.resp_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_esp(input logic [31:0] v);
    @(negedge clk);
    bus.esp_load = 1'b1;
    bus.esp_in   = v;
    @(negedge clk);
    bus.esp_load = 1'b0;
  endtask

  initial begin
    int lat;
    int wr0;
    int rv0;
    bus.op_valid = 1'b0;
    bus.op_code  = 2'b00;
    bus.op_wdata = '0;
    bus.esp_load = 1'b0;
    bus.esp_in   = '0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_esp", bus.esp, 32'h200);
    check("rst_ready", {31'b0, bus.op_ready}, 32'h0);
    check("rst_rv", {31'b0, bus.resp_valid}, 32'h0);
    check("rst_rdata", bus.resp_data, 32'h0);
    check("rst_err", {31'b0, bus.resp_err}, 32'h0);
    check("rst_we", {31'b0, bus.mem_we}, 32'h0);
    check("rst_addr", bus.mem_addr, 32'h200);
    check("rst_wdata", bus.mem_wdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", {31'b0, bus.op_ready}, 32'h1);

    // 1: single push
    run_op(2'b01, 32'hDEADBEEF, lat);
    check("t1_lat", lat, 3);
    check("t1_wrcnt", wr_cnt, 1);
    check("t1_addr", last_addr, 32'h1FC);
    check("t1_data", last_data, 32'hDEADBEEF);
    check("t1_esp", bus.esp, 32'h1FC);
    check("t1_err", {31'b0, bus.resp_err}, 32'h0);

    // 2: push 1, push 2, pop, pop
    do_reset();
    run_op(2'b01, 32'h1, lat);
    run_op(2'b01, 32'h2, lat);
    check("t2_esp_mid", bus.esp, 32'h1F8);
    run_op(2'b10, 32'h0, lat);
    check("t2_pop1_lat", lat, 3);
    check("t2_pop1", bus.resp_data, 32'h2);
    check("t2_esp_pop1", bus.esp, 32'h1FC);
    run_op(2'b10, 32'h0, lat);
    check("t2_pop2", bus.resp_data, 32'h1);
    check("t2_esp_end", bus.esp, 32'h200);
    check("t2_bytes", {ram[10'h1F8], ram[10'h1F9], ram[10'h1FA], ram[10'h1FB]}, 32'h02000000);

    // 3: peek after push
    do_reset();
    run_op(2'b01, 32'h12345678, lat);
    wr0 = wr_cnt;
    run_op(2'b11, 32'h0, lat);
    check("t3_lat", lat, 2);
    check("t3_data", bus.resp_data, 32'h12345678);
    check("t3_esp", bus.esp, 32'h1FC);
    check("t3_nowr", wr_cnt, wr0);
    run_op(2'b00, 32'h0, lat);
    check("t3_rsvd_data", bus.resp_data, 32'h12345678);
    check("t3_rsvd_esp", bus.esp, 32'h1FC);

    // 4: esp_load blocks accept for one cycle
    do_reset();
    @(negedge clk);
    bus.esp_load = 1'b1;
    bus.esp_in   = 32'h100;
    bus.op_valid = 1'b1;
    bus.op_code  = 2'b01;
    bus.op_wdata = 32'hAA;
    #1;
    check("t4_ready_lo", {31'b0, bus.op_ready}, 32'h0);
    @(negedge clk);
    check("t4_esp_load", bus.esp, 32'h100);
    bus.esp_load = 1'b0;
    #1;
    check("t4_ready_hi", {31'b0, bus.op_ready}, 32'h1);
    @(negedge clk);
    bus.op_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("t4_lat", lat, 3);
    check("t4_esp", bus.esp, 32'hFC);
    check("t4_addr", last_addr, 32'hFC);
    check("t4_data", last_data, 32'hAA);

    // Unaligned esp_in is used as-is
    load_esp(32'h103);
    run_op(2'b01, 32'hCAFEF00D, lat);
    check("ua_addr", last_addr, 32'hFF);
    check("ua_esp", bus.esp, 32'hFF);
    run_op(2'b10, 32'h0, lat);
    check("ua_pop", bus.resp_data, 32'hCAFEF00D);
    check("ua_esp2", bus.esp, 32'h103);

    // 5: reset in PUSH_WR
    do_reset();
    wr0 = wr_cnt;
    rv0 = rv_cnt;
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = 2'b01;
    bus.op_wdata = 32'h55;
    @(negedge clk);
    bus.op_valid = 1'b0;
    @(negedge clk);
    check("t5_we_hi", {31'b0, bus.mem_we}, 32'h1);
    reset = 1'b1;
    #1;
    check("t5_we_drop", {31'b0, bus.mem_we}, 32'h0);
    check("t5_esp", bus.esp, 32'h200);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_nowr", wr_cnt, wr0);
    check("t5_norv", rv_cnt, rv0);
    check("t5_esp_after", bus.esp, 32'h200);

    // 6: pop from an empty stack, and push below the limit
    run_op(2'b10, 32'h0, lat);
    check("t6_lat", lat, 3);
    check("t6_data", bus.resp_data, 32'h0);
`ifdef STACK_BOUNDS_CHECK_EN
    check("t6_err", {31'b0, bus.resp_err}, 32'h1);
    check("t6_esp", bus.esp, 32'h200);
`else
    check("t6_err", {31'b0, bus.resp_err}, 32'h0);
    check("t6_esp", bus.esp, 32'h204);
`endif
    load_esp(32'h0);
    wr0 = wr_cnt;
    run_op(2'b01, 32'h77, lat);
    check("wrap_lat", lat, 3);
`ifdef STACK_BOUNDS_CHECK_EN
    check("wrap_err", {31'b0, bus.resp_err}, 32'h1);
    check("wrap_esp", bus.esp, 32'h0);
    check("wrap_nowr", wr_cnt, wr0);
`else
    check("wrap_err", {31'b0, bus.resp_err}, 32'h0);
    check("wrap_esp", bus.esp, 32'hFFFFFFFC);
    check("wrap_addr", last_addr, 32'hFFFFFFFC);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
